commit_trace_serializer: RTL and testbench
==========================================

COMMIT_TRACE_SERIALIZER -- requirements
Module: commit_trace_serializer

Interface
REQ-001 The block SHALL have parameter XLEN, default riscv_pkg::XLEN (32); it is the pc, instruction and register data width.
REQ-002 The block SHALL have parameter DEPTH, default 8; it is the FIFO entry count, a power of two, at least 2.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_i  input  1  asynchronous reset, active-high.
REQ-006 c0_valid_i / c1_valid_i  input  1 each  retire slot 0 (older) / slot 1 (younger) valid.
REQ-007 c0_pc_i / c1_pc_i  input  XLEN each  pc of the retired instruction.
REQ-008 c0_instr_i / c1_instr_i  input  XLEN each  encoding of the retired instruction.
REQ-009 c0_rd_i / c1_rd_i  input  5 each  destination register; 0 means no write.
REQ-010 c0_rd_data_i / c1_rd_data_i  input  XLEN each  write-back value.
REQ-011 accept_o  output  1  retire slots are accepted this cycle.
REQ-012 ready_i  input  1  the trace sink consumes the current output entry.
REQ-013 update_o  output  1  the output entry is valid.
REQ-014 pc_o, instr_o  output  XLEN each  trace entry pc and instruction.
REQ-015 reg_addr_o  output  5  trace entry rd.
REQ-016 reg_data_o  output  XLEN  trace entry rd value.
REQ-017 overflow_o  output  1  sticky flag: a commit was dropped.
REQ-018 retired_o  output  32  count of entries popped.

Function
REQ-019 accept_o SHALL be combinational and equal 1 exactly when the free entry count is at least 2, counted before this cycle's pop.
REQ-020 On a rising edge with accept_o=1, each valid slot SHALL be pushed in order: slot 0 first, then slot 1.
- If only slot 1 is valid, it SHALL be pushed alone into one entry.
REQ-021 A push SHALL store rd_data as 0 when rd=0, whatever the input value.
REQ-022 When accept_o=0 and any slot is valid, nothing SHALL be pushed and overflow_o SHALL be set to 1 on that edge.
- overflow_o SHALL stay at 1 until reset.
REQ-023 The output entry SHALL be driven from the FIFO head.
- update_o SHALL be 1 exactly when the FIFO is non-empty.
- When update_o=0, pc_o, instr_o, reg_addr_o and reg_data_o SHALL be 0.
REQ-024 A pop SHALL occur on a rising edge when update_o=1 and ready_i=1.
- When update_o=1 and ready_i=0, the output entry SHALL stay unchanged.
REQ-025 An entry pushed at edge N SHALL appear on the outputs no earlier than after edge N; there is no bypass from inputs to outputs.
REQ-026 A push and a pop in the same cycle SHALL both take effect.
- occupancy_next = occupancy + pushes - pop, never exceeding DEPTH.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
- Occupancy SHALL use log2(DEPTH)+1 bits so full and empty are distinguishable.
REQ-028 retired_o SHALL increment by 1 on every pop and wrap from 0xFFFFFFFF to 0.
REQ-029 Entry order on the outputs SHALL equal program order: slot 0 before slot 1, and earlier cycles before later ones.

Reset
REQ-030 When rst_i is asserted, at any time including mid-push or mid-pop, the block SHALL immediately empty the FIFO.
- Outputs SHALL go to update_o=0, accept_o=1, overflow_o=0, retired_o=0, and all data outputs 0.
REQ-031 Pushes and pops SHALL be suppressed on any edge where rst_i=1.
- The first push SHALL be possible on the first rising edge after rst_i deasserts.

Verification
REQ-032 Dual retire:
- Stimulus: ready_i=1; c0 = pc 0x80000000, instr 0x00500093, rd 1, data 5; c1 = pc 0x80000004, instr 0x00000013, rd 0, data 0xDEAD.
- Response: the next cycle shows update_o=1, pc 0x80000000, x1, 0x00000005; the following cycle shows pc 0x80000004, reg_addr_o 0, reg_data_o 0; then retired_o=2.
REQ-033 Backpressure to full:
- Stimulus: DEPTH=8, ready_i=0, dual retire for 4 cycles, then a fifth dual retire.
- Response: accept_o=0 after the 4th push, the fifth pair is dropped, overflow_o=1, and occupancy is 8.
REQ-034 Simultaneous push and pop at occupancy 6:
- Stimulus: ready_i=1 with a dual retire.
- Response: occupancy becomes 7, and accept_o stays 0 in the next cycle (free = 1).
REQ-035 Pointer wrap:
- Stimulus: 20 single-slot retires with ready_i toggling every cycle.
- Response: all 20 pcs emerge in order, with no loss and no duplication.
REQ-036 Reset mid-stream:
- Stimulus: assert rst_i asynchronously with occupancy 5.
- Response: update_o=0 and retired_o=0 with no clock edge; after release, a new retire emerges first.

Source files
------------

// File: rtl/commit_trace_serializer.sv
// commit_trace_serializer
// Collects up to two retired instructions per cycle from a dual-issue commit
// stage and serializes them, oldest first, into a single-entry-per-cycle
// trace stream through a DEPTH-entry FIFO.
//
// Ports
//   clk_i                  sole clock, rising edge
//   rst_i                  asynchronous reset, active-high
//   c0_* / c1_*            retire slot 0 (older) and slot 1 (younger):
//                          valid, pc, instr, rd, rd_data
//   accept_o               retire slots are accepted this cycle (free >= 2)
//   ready_i                trace sink consumes the current output entry
//   update_o               output entry valid (FIFO non-empty)
//   pc_o, instr_o          head entry pc / instruction
//   reg_addr_o, reg_data_o head entry rd / rd value
//   overflow_o             sticky: a commit was dropped
//   retired_o              count of entries popped (wraps)
module commit_trace_serializer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            c0_valid_i,
    input  logic [XLEN-1:0] c0_pc_i,
    input  logic [XLEN-1:0] c0_instr_i,
    input  logic [4:0]      c0_rd_i,
    input  logic [XLEN-1:0] c0_rd_data_i,
    input  logic            c1_valid_i,
    input  logic [XLEN-1:0] c1_pc_i,
    input  logic [XLEN-1:0] c1_instr_i,
    input  logic [4:0]      c1_rd_i,
    input  logic [XLEN-1:0] c1_rd_data_i,
    output logic            accept_o,
    input  logic            ready_i,
    output logic            update_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic [4:0]      reg_addr_o,
    output logic [XLEN-1:0] reg_data_o,
    output logic            overflow_o,
    output logic [31:0]     retired_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);
    localparam logic [AW:0] C_TWO   = (AW + 1)'(2);

    // FIFO storage; contents are only observable through update_o gating,
    // so the arrays carry no reset.
    logic [XLEN-1:0] r_mem_pc    [DEPTH];
    logic [XLEN-1:0] r_mem_instr [DEPTH];
    logic [4:0]      r_mem_rd    [DEPTH];
    logic [XLEN-1:0] r_mem_data  [DEPTH];

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [31:0]   r_retired;

    logic [AW:0]     w_free;
    logic            w_accept;
    logic            w_empty;
    logic            w_pop;
    logic            w_push0;
    logic            w_push1;
    logic [AW:0]     w_push_cnt;
    logic [AW-1:0]   w_slot1_ptr;
    logic [XLEN-1:0] w_data0;
    logic [XLEN-1:0] w_data1;

    // Push/pop control derived from occupancy before this cycle's pop.
    always_comb begin
        w_free      = C_DEPTH - r_count;
        w_accept    = (w_free >= C_TWO);
        w_empty     = (r_count == {(AW + 1){1'b0}});
        w_pop       = (!w_empty) && ready_i;
        w_push0     = w_accept && c0_valid_i;
        w_push1     = w_accept && c1_valid_i;
        w_push_cnt  = (AW + 1)'(w_push0) + (AW + 1)'(w_push1);
        // Slot 1 lands right behind slot 0, or alone at the write pointer.
        if (w_push0) begin
            w_slot1_ptr = r_wptr + AW'(1);
        end else begin
            w_slot1_ptr = r_wptr;
        end
        // x0 is never written, so its trace value is forced to zero.
        if (c0_rd_i == 5'd0) begin
            w_data0 = {XLEN{1'b0}};
        end else begin
            w_data0 = c0_rd_data_i;
        end
        if (c1_rd_i == 5'd0) begin
            w_data1 = {XLEN{1'b0}};
        end else begin
            w_data1 = c1_rd_data_i;
        end
    end

    // FIFO storage write port for both retire slots.
    always_ff @(posedge clk_i) begin
        if (w_push0 && !rst_i) begin
            r_mem_pc[r_wptr]    <= c0_pc_i;
            r_mem_instr[r_wptr] <= c0_instr_i;
            r_mem_rd[r_wptr]    <= c0_rd_i;
            r_mem_data[r_wptr]  <= w_data0;
        end
        if (w_push1 && !rst_i) begin
            r_mem_pc[w_slot1_ptr]    <= c1_pc_i;
            r_mem_instr[w_slot1_ptr] <= c1_instr_i;
            r_mem_rd[w_slot1_ptr]    <= c1_rd_i;
            r_mem_data[w_slot1_ptr]  <= w_data1;
        end
    end

    // Pointers, occupancy, sticky overflow and retire counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr     <= {AW{1'b0}};
            r_rptr     <= {AW{1'b0}};
            r_count    <= {(AW + 1){1'b0}};
            r_overflow <= 1'b0;
            r_retired  <= 32'd0;
        end else begin
            // Pointer arithmetic wraps naturally because DEPTH is a power of two.
            r_wptr    <= r_wptr + w_push_cnt[AW-1:0];
            r_rptr    <= r_rptr + AW'(w_pop);
            r_count   <= r_count + w_push_cnt - (AW + 1)'(w_pop);
            r_retired <= r_retired + 32'(w_pop);
            if ((!w_accept) && (c0_valid_i || c1_valid_i)) begin
                r_overflow <= 1'b1;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    // Head entry presentation; data outputs are zero while the FIFO is empty.
    always_comb begin
        if (!w_empty) begin
            pc_o       = r_mem_pc[r_rptr];
            instr_o    = r_mem_instr[r_rptr];
            reg_addr_o = r_mem_rd[r_rptr];
            reg_data_o = r_mem_data[r_rptr];
        end else begin
            pc_o       = {XLEN{1'b0}};
            instr_o    = {XLEN{1'b0}};
            reg_addr_o = 5'd0;
            reg_data_o = {XLEN{1'b0}};
        end
    end

    assign accept_o   = w_accept;
    assign update_o   = !w_empty;
    assign overflow_o = r_overflow;
    assign retired_o  = r_retired;

endmodule

// File: tb/tb_commit_trace_serializer.sv
module tb_commit_trace_serializer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            c0_valid_i, c1_valid_i;
    logic [XLEN-1:0] c0_pc_i, c0_instr_i, c0_rd_data_i;
    logic [XLEN-1:0] c1_pc_i, c1_instr_i, c1_rd_data_i;
    logic [4:0]      c0_rd_i, c1_rd_i;
    logic            accept_o, ready_i, update_o, overflow_o;
    logic [XLEN-1:0] pc_o, instr_o, reg_data_o;
    logic [4:0]      reg_addr_o;
    logic [31:0]     retired_o;

    commit_trace_serializer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .c0_valid_i(c0_valid_i), .c0_pc_i(c0_pc_i), .c0_instr_i(c0_instr_i),
        .c0_rd_i(c0_rd_i), .c0_rd_data_i(c0_rd_data_i),
        .c1_valid_i(c1_valid_i), .c1_pc_i(c1_pc_i), .c1_instr_i(c1_instr_i),
        .c1_rd_i(c1_rd_i), .c1_rd_data_i(c1_rd_data_i),
        .accept_o(accept_o), .ready_i(ready_i), .update_o(update_o),
        .pc_o(pc_o), .instr_o(instr_o), .reg_addr_o(reg_addr_o),
        .reg_data_o(reg_data_o), .overflow_o(overflow_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Reference model: an in-order queue of trace entries plus two scalars.
    ent_t        m_q[$];
    logic        m_ovf;
    logic [31:0] m_ret;
    int          total;
    int          bad;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("update", 32'(update_o), 32'(m_q.size() != 0));
        check_val("accept", 32'(accept_o), 32'((DEPTH - m_q.size()) >= 2));
        check_val("overflow", 32'(overflow_o), 32'(m_ovf));
        check_val("retired", retired_o, m_ret);
        if (m_q.size() != 0) begin
            check_val("pc", pc_o, m_q[0].pc);
            check_val("instr", instr_o, m_q[0].instr);
            check_val("rd", 32'(reg_addr_o), 32'(m_q[0].rd));
            check_val("rd_data", reg_data_o, m_q[0].data);
        end else begin
            check_val("pc_idle", pc_o, 32'd0);
            check_val("instr_idle", instr_o, 32'd0);
            check_val("rd_idle", 32'(reg_addr_o), 32'd0);
            check_val("data_idle", reg_data_o, 32'd0);
        end
    endtask

    // Apply one rising edge to the model using the currently driven inputs.
    task automatic model_edge();
        ent_t e;
        bit   acc;
        acc = (DEPTH - m_q.size()) >= 2;
        if (m_q.size() != 0 && ready_i) begin
            void'(m_q.pop_front());
            m_ret++;
        end
        if (acc) begin
            if (c0_valid_i) begin
                e = '{c0_pc_i, c0_instr_i, c0_rd_i, (c0_rd_i == 5'd0) ? 32'd0 : c0_rd_data_i};
                m_q.push_back(e);
            end
            if (c1_valid_i) begin
                e = '{c1_pc_i, c1_instr_i, c1_rd_i, (c1_rd_i == 5'd0) ? 32'd0 : c1_rd_data_i};
                m_q.push_back(e);
            end
        end else if (c0_valid_i || c1_valid_i) begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic set_slot0(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [4:0] rd, input logic [31:0] d);
        c0_valid_i = v; c0_pc_i = pc; c0_instr_i = ins; c0_rd_i = rd; c0_rd_data_i = d;
    endtask

    task automatic set_slot1(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [4:0] rd, input logic [31:0] d);
        c1_valid_i = v; c1_pc_i = pc; c1_instr_i = ins; c1_rd_i = rd; c1_rd_data_i = d;
    endtask

    // Called at a falling edge: clock once, update the model, check at the next falling edge.
    task automatic step(input logic rdy);
        ready_i = rdy;
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        check_all();
    endtask

    task automatic idle_step(input logic rdy);
        set_slot0(1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
        set_slot1(1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
        step(rdy);
    endtask

    task automatic rand_slots(input logic v0, input logic v1);
        logic [4:0] rd0, rd1;
        rd0 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        rd1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        set_slot0(v0, $urandom, $urandom, rd0, $urandom);
        set_slot1(v1, $urandom, $urandom, rd1, $urandom);
    endtask

    task automatic drain(input int expected_pops);
        int pops;
        pops = 0;
        for (int k = 0; k < 40 && update_o; k++) begin
            idle_step(1'b1);
            pops++;
        end
        check_val("drain_pops", 32'(pops), 32'(expected_pops));
        check_val("drained", 32'(update_o), 32'd0);
    endtask

    initial begin
        int sent;
        total = 0; bad = 0;
        m_ovf = 1'b0; m_ret = 32'd0;
        rst_i = 1'b1; ready_i = 1'b0;
        set_slot0(1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
        set_slot1(1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_all();
        rst_i = 1'b0;

        // Dual retire with rd=0 on the younger slot.
        set_slot0(1'b1, 32'h8000_0000, 32'h0050_0093, 5'd1, 32'd5);
        set_slot1(1'b1, 32'h8000_0004, 32'h0000_0013, 5'd0, 32'h0000_DEAD);
        step(1'b1);
        check_val("dual_pc0", pc_o, 32'h8000_0000);
        check_val("dual_rd0", 32'(reg_addr_o), 32'd1);
        check_val("dual_data0", reg_data_o, 32'd5);
        idle_step(1'b1);
        check_val("dual_pc1", pc_o, 32'h8000_0004);
        check_val("dual_data1", reg_data_o, 32'd0);
        idle_step(1'b1);
        check_val("dual_retired", retired_o, 32'd2);

        // Backpressure to full, then a dropped pair.
        for (int i = 0; i < 4; i++) begin
            rand_slots(1'b1, 1'b1);
            step(1'b0);
        end
        check_val("full_accept", 32'(accept_o), 32'd0);
        rand_slots(1'b1, 1'b1);
        step(1'b0);
        check_val("full_overflow", 32'(overflow_o), 32'd1);
        // Pop two (occupancy 6), then push two while popping one.
        idle_step(1'b1);
        idle_step(1'b1);
        check_val("occ6_accept", 32'(accept_o), 32'd1);
        rand_slots(1'b1, 1'b1);
        step(1'b1);
        check_val("occ7_accept", 32'(accept_o), 32'd0);
        drain(7);

        // Single-slot retires with ready toggling every cycle; no losses.
        sent = 0;
        for (int c = 0; c < 200 && sent < 20; c++) begin
            if (accept_o) begin
                rand_slots((sent % 2) == 0, (sent % 2) == 1);
                c0_pc_i = 32'h9000_0000 + 32'(sent * 4);
                c1_pc_i = 32'h9000_0000 + 32'(sent * 4);
                sent++;
            end else begin
                rand_slots(1'b0, 1'b0);
            end
            step(1'(c % 2));
        end
        check_val("wrap_sent", 32'(sent), 32'd20);
        drain(m_q.size());

        // Reset mid-stream at occupancy 5.
        rand_slots(1'b1, 1'b1); step(1'b0);
        rand_slots(1'b1, 1'b1); step(1'b0);
        rand_slots(1'b1, 1'b0); step(1'b0);
        idle_step(1'b0);
        #2 rst_i = 1'b1;
        #1;
        check_val("rst_update", 32'(update_o), 32'd0);
        check_val("rst_retired", retired_o, 32'd0);
        check_val("rst_accept", 32'(accept_o), 32'd1);
        check_val("rst_overflow", 32'(overflow_o), 32'd0);
        check_val("rst_pc", pc_o, 32'd0);
        m_q.delete(); m_ovf = 1'b0; m_ret = 32'd0;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_all();
        set_slot0(1'b1, 32'h1234_5678, 32'h0000_0013, 5'd3, 32'h0000_00AA);
        set_slot1(1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
        step(1'b0);
        check_val("post_rst_pc", pc_o, 32'h1234_5678);
        drain(1);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rand_slots(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step(1'($urandom_range(0, 2) != 0));
        end
        drain(m_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
